// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the frame-memory reader scheduler.
// Holds the read opcode, FSM state encoding and default frame size.
package frame_sequencer_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int FRAME_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT
  } state_t;

endpackage

// File: rtl/bell_sync_edge.sv
// Bell input synchroniser: two flops into the clk domain, then a
// rising-edge pulse. Ports: clk, rst_n, bell (async level), rise (pulse).
module bell_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic bell,
  output logic rise
);

  // [0],[1] are the synchroniser, [2] holds the previous synced level
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= 3'b000;
    end else begin
      sr <= {sr[1:0], bell};
    end
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/frame_sequencer.sv
// Frame-load scheduler for the SPI frame-memory reader.
// In: clk, rst_n, layer_cfg, bell, rd_done. Out: rd_start, rd_cmd,
// rd_first, frame_strobe, anim_active, err_timeout.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int ADDR_W      = 19,
  parameter int NUM_LAYERS  = 3,
  parameter int TICK_NORM   = 33554432,
  parameter int TICK_ANIM   = 2097152,
  parameter int ANIM_LEN    = 300,
  parameter int TIMEOUT     = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] layer_cfg,
  input  logic        bell,
  output logic        rd_start,
  output logic [31:0] rd_cmd,
  output logic        rd_first,
  input  logic        rd_done,
  output logic        frame_strobe,
  output logic        anim_active,
  output logic        err_timeout
);

  localparam int TMAX =
    (TICK_NORM > TICK_ANIM) ? TICK_NORM : TICK_ANIM;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IW = (ANIM_LEN > 1) ? $clog2(ANIM_LEN) : 1;

  localparam logic [TW-1:0] TN_LAST = TW'(TICK_NORM - 1);
  localparam logic [TW-1:0] TA_LAST = TW'(TICK_ANIM - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [IW-1:0] AN_LAST = IW'(ANIM_LEN - 1);
  localparam logic [1:0]    LY_LAST = 2'(NUM_LAYERS - 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic            pending;
  logic [31:0]     snap;
  logic [1:0]      layer;
  logic [IW-1:0]   anim_idx;
  logic [7:0]      anim_base;
  logic            frame_anim;
  logic [WW-1:0]   wdog;

  logic            bell_rise;
  logic            tick;
  logic [7:0]      layer_byte;
  logic [31:0]     frame_idx;
  logic [ADDR_W-1:0] addr;

  bell_sync_edge u_bell (
    .clk   (clk),
    .rst_n (rst_n),
    .bell  (bell),
    .rise  (bell_rise)
  );

  always_comb begin
    tick       = (timer == (anim_active ? TA_LAST : TN_LAST));
    layer_byte = snap[{layer, 3'b000} +: 8];
    if (frame_anim) begin
      frame_idx = 32'(anim_base) + 32'(anim_idx);
    end else begin
      frame_idx = 32'(layer_byte);
    end
    // truncation gives the mod 2^ADDR_W wrap
    addr = ADDR_W'(frame_idx * 32'(FRAME_BYTES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      pending      <= 1'b0;
      snap         <= '0;
      layer        <= '0;
      anim_idx     <= '0;
      anim_base    <= '0;
      frame_anim   <= 1'b0;
      wdog         <= '0;
      rd_start     <= 1'b0;
      rd_cmd       <= {CMD_READ, 24'h0};
      rd_first     <= 1'b1;
      frame_strobe <= 1'b0;
      anim_active  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      rd_start     <= 1'b0;
      frame_strobe <= 1'b0;

      if (tick) begin
        timer   <= '0;
        pending <= 1'b1;
      end else begin
        timer <= timer + TW'(1);
      end

      // a mode change restarts the tick period from zero
      if (bell_rise && !anim_active) begin
        anim_active <= 1'b1;
        anim_idx    <= '0;
        anim_base   <= layer_cfg[31:24];
        timer       <= '0;
      end

      unique case (state)
        IDLE: begin
          if (pending) begin
            // a tick landing on this cycle stays pending
            pending    <= tick;
            snap       <= layer_cfg;
            layer      <= '0;
            frame_anim <= anim_active;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rd_cmd   <= {CMD_READ, 24'(addr)};
          rd_first <= frame_anim | (layer == 2'd0);
          rd_start <= 1'b1;
          wdog     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (rd_done) begin
            state <= NEXT;
          end else if (wdog == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        NEXT: begin
          if (frame_anim) begin
            frame_strobe <= 1'b1;
            state        <= IDLE;
            if (anim_idx == AN_LAST) begin
              anim_active <= 1'b0;
              anim_idx    <= '0;
              timer       <= '0;
            end else begin
              anim_idx <= anim_idx + IW'(1);
            end
          end else if (layer != LY_LAST) begin
            layer <= layer + 2'd1;
            state <= ISSUE;
          end else begin
            frame_strobe <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a small reader responder,
// a start/strobe logger and hand-computed expected vectors.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bell;
  logic        rd_done;
  logic [31:0] layer_cfg;

  logic        rd_start, rd_first, frame_strobe;
  logic        anim_active, err_timeout;
  logic [31:0] rd_cmd;
  logic        rd_start_b, rd_first_b, frame_strobe_b;
  logic        anim_active_b, err_timeout_b;
  logic [31:0] rd_cmd_b;

  frame_sequencer #(
    .ADDR_W(19), .TICK_NORM(32), .TICK_ANIM(16),
    .ANIM_LEN(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .layer_cfg(layer_cfg),
    .bell(bell), .rd_start(rd_start), .rd_cmd(rd_cmd),
    .rd_first(rd_first), .rd_done(rd_done),
    .frame_strobe(frame_strobe), .anim_active(anim_active),
    .err_timeout(err_timeout)
  );

  frame_sequencer #(
    .ADDR_W(18), .TICK_NORM(32), .TICK_ANIM(16),
    .ANIM_LEN(4), .TIMEOUT(64)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .layer_cfg(layer_cfg),
    .bell(bell), .rd_start(rd_start_b), .rd_cmd(rd_cmd_b),
    .rd_first(rd_first_b), .rd_done(rd_done),
    .frame_strobe(frame_strobe_b), .anim_active(anim_active_b),
    .err_timeout(err_timeout_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int n_start = 0;
  int n_strobe = 0;
  int n_done = 0;
  int last_strobe = 0;
  int done_at_strobe = 0;
  int overlap = 0;
  int done_delay = 10;
  bit outst = 0;
  logic err_q = 1'b0;
  int          st_cyc[256];
  logic [31:0] st_cmd[256];
  logic [31:0] st_cmd_b[256];
  logic        st_first[256];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) outst = 0;
    if (rd_done === 1'b1) begin
      n_done++;
      outst = 0;
    end
    if (err_timeout === 1'b1 && err_q !== 1'b1) outst = 0;
    err_q = err_timeout;
    if (rd_start === 1'b1) begin
      if (outst) overlap++;
      outst = 1;
      if (n_start < 256) begin
        st_cyc[n_start]   = cyc;
        st_cmd[n_start]   = rd_cmd;
        st_cmd_b[n_start] = rd_cmd_b;
        st_first[n_start] = rd_first;
      end
      n_start++;
    end
    if (frame_strobe === 1'b1) begin
      n_strobe++;
      last_strobe = cyc;
      done_at_strobe = n_done;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rd_start === 1'b1 && done_delay > 0) begin
      repeat (done_delay - 1) @(negedge clk);
      #2 rd_done = 1'b1;
      @(negedge clk);
      #2 rd_done = 1'b0;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int n, input int lim,
                             input string tag);
    int k = 0;
    while (n_start < n && k < lim) begin
      tick_n(1);
      k++;
    end
    chk(tag, 32'(n_start >= n), 1);
  endtask

  task automatic wait_strobes(input int n, input int lim,
                              input string tag);
    int k = 0;
    while (n_strobe < n && k < lim) begin
      tick_n(1);
      k++;
    end
    chk(tag, 32'(n_strobe >= n), 1);
  endtask

  task automatic wait_anim(input logic v, input int lim,
                           input string tag);
    int k = 0;
    while (anim_active !== v && k < lim) begin
      tick_n(1);
      k++;
    end
    chk(tag, 32'(anim_active), 32'(v));
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_start"}, 32'(rd_start), 0);
    chk({p, "_cmd"}, rd_cmd, 32'h0300_0000);
    chk({p, "_cmd_b"}, rd_cmd_b, 32'h0300_0000);
    chk({p, "_first"}, 32'(rd_first), 1);
    chk({p, "_strobe"}, 32'(frame_strobe), 0);
    chk({p, "_anim"}, 32'(anim_active), 0);
    chk({p, "_err"}, 32'(err_timeout), 0);
  endtask

  task automatic do_anim(input bit rebell, input logic [7:0] bf);
    int b;
    int sb;
    int e;
    wait_strobes(n_strobe + 1, 200, "a_pre");
    b = n_start;
    sb = n_strobe;
    bell = 1'b1;
    tick_n(3);
    bell = 1'b0;
    wait_anim(1'b1, 20, "a_rise");
    if (rebell) begin
      wait_starts(b + 2, 200, "a_mid");
      bell = 1'b1;
      tick_n(3);
      bell = 1'b0;
    end
    wait_anim(1'b0, 300, "a_fall");
    chk("a_nstart", 32'(n_start - b), 4);
    chk("a_nstrobe", 32'(n_strobe - sb), 4);
    for (int i = 0; i < 4; i++) begin
      e = (int'(bf) + i) * 1024;
      chk($sformatf("a_addr%0d", i), st_cmd[b + i],
          {8'h03, 24'(e % 524288)});
      chk($sformatf("a_addr18_%0d", i), st_cmd_b[b + i],
          {8'h03, 24'(e % 262144)});
      chk($sformatf("a_first%0d", i), 32'(st_first[b + i]), 1);
      if (i > 0)
        chk($sformatf("a_gap%0d", i),
            32'(st_cyc[b + i] - st_cyc[b + i - 1]), 16);
    end
    wait_starts(b + 5, 100, "a_resume_to");
    chk("a_resume", st_cmd[b + 4],
        {8'h03, 24'(int'(layer_cfg[7:0]) * 1024)});
    chk("a_resume_first", 32'(st_first[b + 4]), 1);
  endtask

  logic [31:0] exp1[3];
  logic        expf[3];
  int b;
  int sb;
  int d0;
  int s;
  int k;
  int ls;
  int n0;

  initial begin
    exp1 = '{32'h0300_0800, 32'h0300_2800, 32'h0300_1400};
    expf = '{1'b1, 1'b0, 1'b0};
    rst_n = 1'b0;
    bell = 1'b0;
    rd_done = 1'b0;
    layer_cfg = 32'h0005_0A02;
    done_delay = 10;
    tick_n(3);
    chk_reset("rst");
    rst_n = 1'b1;

    // three-layer normal frame
    b = n_start;
    d0 = n_done;
    wait_strobes(1, 400, "t1_strobe_to");
    chk("t1_nstart", 32'(n_start - b), 3);
    chk("t1_dones", 32'(done_at_strobe - d0), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_addr%0d", i), st_cmd[b + i], exp1[i]);
      chk($sformatf("t1_first%0d", i), 32'(st_first[b + i]),
          32'(expf[i]));
    end
    done_delay = 2;
    wait_strobes(n_strobe + 4, 600, "t1_settle");

    // animation, then animation with a second bell edge
    layer_cfg = 32'h1005_0A02;
    do_anim(1'b0, 8'h10);
    do_anim(1'b1, 8'h10);

    // reader never answers
    wait_strobes(n_strobe + 1, 200, "t4_pre");
    done_delay = 0;
    b = n_start;
    sb = n_strobe;
    wait_starts(b + 1, 100, "t4_start");
    s = st_cyc[b];
    k = 0;
    while (err_timeout !== 1'b1 && k < 200) begin
      tick_n(1);
      k++;
    end
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_lat", 32'(cyc - s), 64);
    chk("t4_nostrobe", 32'(n_strobe - sb), 0);
    done_delay = 2;
    wait_starts(b + 2, 20, "t4_rec_to");
    chk("t4_rec_addr", st_cmd[b + 1], 32'h0300_0800);
    chk("t4_rec_first", 32'(st_first[b + 1]), 1);
    chk("t4_rec_gap", 32'(st_cyc[b + 1] - s), 66);
    wait_starts(b + 5, 200, "t4_next_to");
    chk("t4_drop", 32'(st_cyc[b + 4] - s), 96);

    // slow reader, ticks overrun
    wait_strobes(n_strobe + 1, 200, "t5_pre");
    done_delay = 40;
    wait_strobes(n_strobe + 1, 600, "t5_slow1");
    ls = last_strobe;
    n0 = n_start;
    wait_starts(n0 + 1, 20, "t5_kept_to");
    chk("t5_kept", 32'(st_cyc[n0] - ls), 2);
    chk("t5_first", 32'(st_first[n0]), 1);
    wait_strobes(n_strobe + 1, 600, "t5_slow2");
    chk("t5_overlap", 32'(overlap), 0);
    done_delay = 2;
    wait_strobes(n_strobe + 4, 800, "t5_settle");

    // address wrap at base 0xFF
    layer_cfg = 32'hFF05_0A02;
    do_anim(1'b0, 8'hFF);

    // reset while waiting on an animation read
    wait_strobes(n_strobe + 1, 200, "t6_pre");
    done_delay = 30;
    bell = 1'b1;
    tick_n(3);
    bell = 1'b0;
    wait_anim(1'b1, 20, "t6_rise");
    b = n_start;
    wait_starts(b + 1, 100, "t6_start");
    tick_n(5);
    rst_n = 1'b0;
    tick_n(1);
    chk_reset("t6");
    rst_n = 1'b1;
    done_delay = 2;
    b = n_start;
    wait_starts(b + 1, 100, "t6_next_to");
    chk("t6_addr", st_cmd[b], 32'h0300_0800);
    chk("t6_first", 32'(st_first[b]), 1);
    chk("t6_anim", 32'(anim_active), 0);
    chk("t6_overlap", 32'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Scheduler for the SPI frame-memory reader (the serial-flash shift datapath).
- Decides when a frame load starts, which frame-memory address is read, and whether each load overwrites or ORs into the display buffer.
- Replaces the ad-hoc free-running trigger and bell counter with one explicit state machine and a start/done handshake.
- Sits between the frame-select register / bell input and the reader; the reader raises a done pulse after its last data bit.

Parameters:
- FRAME_BYTES, 1024: bytes per frame in flash; address = FRAME_BYTES * frame index.
- ADDR_W, 19: flash address width; the address is truncated mod 2^ADDR_W.
- NUM_LAYERS, 3: byte slots of layer_cfg composited per normal frame (slot 0 first).
- TICK_NORM, 33554432: clk cycles between frame starts in normal mode.
- TICK_ANIM, 2097152: clk cycles between frame starts in animation mode.
- ANIM_LEN, 300: frames per bell animation.
- TIMEOUT, 16384: maximum cycles to wait for rd_done before aborting.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- layer_cfg  in  32  byte l = frame index of layer l; byte 3 = animation base frame.
- bell  in  1  asynchronous bell request; level input.
- rd_start  out  1  one-cycle pulse starting a reader transaction.
- rd_cmd  out  32  [31:24]=8'h03 read opcode, [23:ADDR_W]=0, [ADDR_W-1:0]=address; stable from rd_start until rd_done.
- rd_first  out  1  1 = overwrite buffer (layer 0 or animation), 0 = OR into buffer; stable with rd_cmd.
- rd_done  in  1  one-cycle pulse from the reader at the end of its data phase.
- frame_strobe  out  1  one-cycle pulse when a complete frame (all layers) is loaded.
- anim_active  out  1  high while an animation is running.
- err_timeout  out  1  sticky flag: a transaction was aborted; cleared only by reset.

Behaviour:
- Reset values: rd_start=0, rd_cmd={8'h03,24'h0}, rd_first=1, frame_strobe=0, anim_active=0, err_timeout=0. State IDLE, timer=0, pending=0, layer=0, anim_idx=0.
- Timer: counts 0..P-1 then wraps, where P = TICK_ANIM when anim_active, else TICK_NORM. tick = (timer == P-1). P switches on the first cycle anim_active changes, and the timer restarts from 0 at that point.
- Pending: a tick sets pending. A tick while pending is already 1 is dropped (pending stays 1).
- Bell: passes through a 2-flop synchroniser, then a rising-edge detector. An edge while anim_active=0 sets anim_active=1 and anim_idx=0, and loads the base frame from layer_cfg[31:24]. An edge while anim_active=1 is ignored.
- States:
  - IDLE: if pending, clear pending, snapshot layer_cfg, set layer=0, go to ISSUE.
  - ISSUE: drive rd_cmd/rd_first, pulse rd_start for one cycle, clear the watchdog, go to WAIT.
  - WAIT: on rd_done go to NEXT. If the watchdog reaches TIMEOUT-1, set err_timeout, go to IDLE, and do not pulse frame_strobe.
  - NEXT, normal mode: if layer < NUM_LAYERS-1, increment layer and go to ISSUE. Otherwise pulse frame_strobe and go to IDLE.
  - NEXT, animation mode: pulse frame_strobe and increment anim_idx. If anim_idx was ANIM_LEN-1, clear anim_active. Go to IDLE.
- Address: normal mode = FRAME_BYTES * snap[8*layer +: 8]. Animation mode = FRAME_BYTES * (base + anim_idx). Compute at ADDR_W+1 bits and truncate to ADDR_W (wrap).
- rd_first = 1 for layer 0 and for every animation frame; 0 otherwise.
- The layer_cfg snapshot is taken in IDLE→ISSUE. Changes to layer_cfg mid-frame take effect on the next frame only.
- rd_done outside WAIT is ignored. rd_done in the same cycle as a watchdog expiry counts as done, with no error.
- A bell edge while a normal frame is in flight: the current frame completes in normal mode; the mode is re-evaluated at the next IDLE→ISSUE.
- Latency: pending observed in IDLE → rd_start 2 cycles later. rd_done → next rd_start 2 cycles later (NEXT, ISSUE).
- Asserting rst_n low mid-transaction returns immediately to reset values. The reader is expected to be reset by the same rst_n.

Decomposition:
- Shared package/header: the CMD_READ=8'h03 opcode, the state encodings (IDLE, ISSUE, WAIT, NEXT), and a FRAME_BYTES default shared with the reader.
- One natural sub-module: bell_sync_edge (2-flop synchroniser plus rising-edge pulse, async active-low reset).

Test Plan:
All scenarios use TICK_NORM=32, TICK_ANIM=16, ANIM_LEN=4, TIMEOUT=64, NUM_LAYERS=3, FRAME_BYTES=1024.
1. layer_cfg=32'h00050A02; the bench answers each rd_start with rd_done 10 cycles later → three rd_start pulses with addresses 0x00800, 0x02800, 0x01400 and rd_first 1,0,0; one frame_strobe after the third rd_done.
2. Bell held high for 3 cycles with layer_cfg[31:24]=8'h10 → anim_active rises. Four single-layer reads at addresses 0x04000, 0x04400, 0x04800, 0x04C00, all with rd_first=1, spaced 16 cycles apart. anim_active falls after the fourth frame_strobe; normal mode then resumes.
3. Second bell edge during an animation → ignored. Exactly 4 animation frames occur and anim_idx is not restarted.
4. Bench never returns rd_done → err_timeout=1 64 cycles after rd_start, with no frame_strobe. The next tick issues a fresh rd_start for layer 0.
5. rd_done delayed 40 cycles so that ticks overrun → one pending tick is kept and extra ticks are dropped. No two rd_start pulses occur without an intervening rd_done or timeout.
6. rst_n low for 1 cycle while in WAIT; layer_cfg[31:24]=8'hFF with animation → all outputs return to their reset values and the next read starts at layer 0. The wrap case gives address (0xFF+3)*1024 mod 2^19 = 0x40800 (no wrap at ADDR_W=19). Repeat with ADDR_W=18 → 0x00800.
